key_event_sched: RTL
====================

Name: key_event_sched

Overview:
- Sits between KeyboardDecoder and the game/display logic.
- Converts decoder key_valid pulses into an ordered queue of press/release events.
- Generates auto-repeat events for the most recently pressed key that is still held.
- Arbitrates between decoder edges and repeat ticks for the single queue write port. The consumer drains the queue with a valid/ready handshake.

Parameters:
DEPTH, 8, queue entries; power of 2, at least 2
REPEAT_DELAY, 50_000_000, cycles from press to first repeat event (at least 2)
REPEAT_RATE, 10_000_000, cycles between subsequent repeat events (at least 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle pulse from KeyboardDecoder: last_change/key_down updated
last_change  input  9  scan code of the changed key
key_down  input  512  held-key bitmap; reflects the new state in the key_valid cycle
repeat_en  input  1  1 = auto-repeat enabled
evt_ready  input  1  consumer accepts head entry
ovf_clr  input  1  clears overflow
evt_valid  output  1  queue not empty
evt_code  output  9  head entry scan code
evt_type  output  2  head entry type: 00 press, 01 release, 10 repeat
count  output  log2(DEPTH)+1  queue occupancy
overflow  output  1  sticky: a press/release was dropped

Behaviour:
- Reset (rst=1 at clk edge): queue empty, count=0, evt_valid=0, evt_code=0, evt_type=0, overflow=0, repeat FSM=IDLE, timer=0. Reset mid-operation discards all queued and pending events.
- Edge capture: on key_valid=1, type = key_down[last_change] ? press : release; code = last_change.
- Queue: show-ahead FIFO. evt_valid = (count != 0). evt_code/evt_type always equal the head entry; both are 0 when the queue is empty.
- Pop occurs when evt_valid && evt_ready.
- A write is visible on the outputs the cycle after key_valid when the queue was empty (1-cycle latency).
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: both occur, count unchanged. This includes the full case: a pop frees the slot, so a simultaneous push is accepted.
- Full with no pop:
  - A press/release is dropped and overflow is set to 1.
  - A repeat is dropped silently; overflow is unchanged.
- overflow: sticky until ovf_clr=1. If a set and a clear occur in the same cycle, the set wins.
- Write arbitration: only one write per cycle. A decoder edge always wins. A repeat tick in the same cycle is discarded, and the repeat timer restarts from 0 in the current state.
- Repeat FSM, timer 32 bits:
  - IDLE: on a press event (written or dropped), latch tracked=code, timer=0, go to DELAY.
  - DELAY: timer increments. When timer == REPEAT_DELAY-1: if repeat_en, issue a repeat tick for tracked; in either case timer=0 and go to REPEAT.
  - REPEAT: timer increments. When timer == REPEAT_RATE-1: issue a repeat tick if repeat_en, then timer=0.
  - In DELAY or REPEAT, a press of a different code re-latches tracked, sets timer=0 and goes to DELAY.
  - In DELAY or REPEAT, a release of the tracked code goes to IDLE. A release of another code is ignored by the FSM but is still queued.
  - Safety: if key_down[tracked]==0 in DELAY or REPEAT with no key_valid that cycle, go to IDLE with no event.
- repeat_en=0 suppresses repeat ticks only; the FSM still runs.
- Repeat tick: writes {tracked, 10} with the same full rules as other writes. Repeat entries are never reordered ahead of earlier entries.
- Arithmetic: count saturates logically at DEPTH (never exceeds it). The timer compare uses ==; there is no wrap within the valid parameter range.

Test Plan (bench: DEPTH=4, REPEAT_DELAY=20, REPEAT_RATE=5):
1. Reset, then key_valid with last_change=0x01C and key_down[0x01C]=1 → next cycle evt_valid=1, evt_code=0x01C, evt_type=00, count=1. Release with bit=0 and evt_ready=1 → entries drained in order press then release.
2. Hold 0x01C, repeat_en=1, evt_ready=1 → first repeat (type 10) written 20 cycles after the press write, then one every 5 cycles. Release → no further repeats.
3. evt_ready=0, send 5 distinct presses (0x015, 0x01D, 0x024, 0x02D, 0x02C) → count=4, overflow=1, head=0x015, 0x02C never appears. ovf_clr → overflow=0.
4. Full queue with evt_ready=1 and key_valid in the same cycle → count stays 4, new entry appended, overflow=0.
5. Repeat tick coincides with a key_valid for 0x029 → only the 0x029 edge entry is written; next repeat arrives 5 cycles later. Press 0x029 while 0x01C is held → repeats switch to 0x029 after 20 cycles.
6. rst asserted with 3 queued entries and FSM in REPEAT → next cycle count=0, evt_valid=0, and no repeat events appear while the key stays held until a new press.

Source files
------------

// File: rtl/key_event_sched.sv
// key_event_sched: queues key press/release edges and auto-repeat ticks for a valid/ready consumer
module key_event_sched #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [8:0]               last_change,
  input  logic [511:0]             key_down,
  input  logic                     repeat_en,
  input  logic                     evt_ready,
  input  logic                     ovf_clr,
  output logic                     evt_valid,
  output logic [8:0]               evt_code,
  output logic [1:0]               evt_type,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] DLY_LIM = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LIM = 32'(REPEAT_RATE - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} state_t;

  state_t       state_q, state_d;
  logic [31:0]  timer_q, timer_d;
  logic [8:0]   trk_q, trk_d;
  logic [10:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]  cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         is_press, hit, tick, full, pop, push, wr;
  logic [10:0]  wdata;

  assign is_press  = key_valid && key_down[last_change];
  assign hit       = (state_q != IDLE) && (timer_q == ((state_q == DELAY) ? DLY_LIM : RATE_LIM));
  assign tick      = hit && repeat_en && !key_valid;
  assign full      = cnt_q == FULL_CNT;
  assign evt_valid = cnt_q != '0;
  assign pop       = evt_valid && evt_ready;
  assign push      = key_valid || tick;
  assign wr        = push && (!full || pop);
  assign wdata     = key_valid ? {last_change, is_press ? 2'b00 : 2'b01} : {trk_q, 2'b10};
  assign evt_code  = evt_valid ? mem_q[rp_q][10:2] : '0;
  assign evt_type  = evt_valid ? mem_q[rp_q][1:0] : '0;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

  // Repeat FSM: decoder edges take priority over timer expiry; a collision just restarts the timer
  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    timer_d = (state_q == IDLE) ? '0 : timer_q + 32'd1;
    if (key_valid) begin
      if (is_press && (state_q == IDLE || last_change != trk_q)) begin
        trk_d   = last_change;
        timer_d = '0;
        state_d = DELAY;
      end else if (!is_press && state_q != IDLE && last_change == trk_q) begin
        timer_d = '0;
        state_d = IDLE;
      end else if (hit) begin
        timer_d = '0;
      end
    end else if (state_q != IDLE && !key_down[trk_q]) begin
      timer_d = '0;
      state_d = IDLE;
    end else if (hit) begin
      timer_d = '0;
      state_d = RPT;
    end
  end

  // Occupancy and sticky overflow; only dropped edges raise overflow, and a set beats a clear
  always_comb begin
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d = (key_valid && full && !pop) || (ovf_q && !ovf_clr);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      trk_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      trk_q   <= trk_d;
      wp_q    <= wr ? wp_q + 1'b1 : wp_q;
      rp_q    <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Queue storage; stale contents are masked by the empty check on the outputs
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= wdata;
  end
endmodule
